// File: rtl/aes_inv_round_engine.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched through keyIdx/roundKey.
// Optional abort input enabled by defining RIJNDAEL_ABORT_EN.
module aes_inv_round_engine (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inValid,
   output logic         inReady,
   input  logic [127:0] cipherIn,
   output logic [3:0]   keyIdx,
   input  logic [127:0] roundKey,
   output logic         outValid,
   input  logic         outReady,
   output logic [127:0] plainOut,
   output logic         busy
`ifdef RIJNDAEL_ABORT_EN
   ,
   input  logic         abort
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

   state_t       state_q, state_d;
   logic [127:0] st_q, st_d;
   logic [127:0] plain_q, plain_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] t_s;
   logic         abort_s;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] s;
      s = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(s);
   endfunction

   // Byte (col c, row r) sits at index 4c+r, byte 0 in the top bits.
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

`ifdef RIJNDAEL_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   assign t_s = inv_shift_sub(st_q) ^ roundKey;

   // Next-state and datapath update for the round FSM.
   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      round_d = round_q;
      plain_d = plain_q;
      case (state_q)
         IDLE: begin
            if (inValid) begin
               st_d    = cipherIn ^ roundKey;
               round_d = 4'd9;
               state_d = ROUND;
            end else begin
               state_d = IDLE;
            end
         end
         ROUND: begin
            if (abort_s) begin
               state_d = IDLE;
            end else if (round_q != 4'd0) begin
               st_d    = inv_mix_columns(t_s);
               round_d = round_q - 4'd1;
            end else begin
               plain_d = t_s;
               state_d = DONE;
            end
         end
         DONE: begin
            if (abort_s || outReady) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, round counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         st_q    <= 128'h0;
         round_q <= 4'd0;
         plain_q <= 128'h0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         round_q <= round_d;
         plain_q <= plain_d;
      end
   end

   assign inReady  = (state_q == IDLE);
   assign outValid = (state_q == DONE);
   assign busy     = (state_q != IDLE);
   assign keyIdx   = (state_q == ROUND) ? round_q : 4'd10;
   assign plainOut = plain_q;

endmodule
